// File: rtl/io_port_pkg.sv
// Shared constants, IRQ state encoding and a clog2 helper for the I/O port bridge.
package io_port_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        WAIT   = 2'd2
    } irq_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
// rdata reads as zero while the FIFO is empty.
module io_sync_fifo
    import io_port_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/io_port_bridge.sv
// Bridge between the core's In_Port/Out_Port and a valid/ready host interface.
// Defining IO_LOOPBACK_EN adds lb_en, which routes OUT words back into the input FIFO.
//   state  | meaning
//   IDLE   | no request pending, waiting for the input FIFO to go non-empty
//   ASSERT | irq high, counting out IRQ_LEN cycles
//   WAIT   | pulse finished, waiting for the input FIFO to drain
module io_port_bridge
    import io_port_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int IRQ_LEN   = 2
) (
    input  logic              clk,
    input  logic              reset,
`ifdef IO_LOOPBACK_EN
    input  logic              lb_en,
`endif
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_wr,
    output logic [DATA_W-1:0] cpu_in_data,
    input  logic              cpu_in_rd,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    output logic              irq,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int IN_CW  = clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = clog2(OUT_DEPTH) + 1;
    localparam int CNT_W  = clog2(IRQ_LEN) + 1;

    logic              in_full, in_empty, in_push, in_pop;
    logic [DATA_W-1:0] in_wdata;
    logic [IN_CW-1:0]  in_count;
    logic              out_full, out_empty, out_push, out_pop;
    logic [DATA_W-1:0] out_rdata;
    logic [OUT_CW-1:0] out_count;
    logic              lb_active, lb_move;
    logic              unused_counts;

    irq_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

`ifdef IO_LOOPBACK_EN
    logic lb_q;
    always_ff @(posedge clk) begin
        if (reset) lb_q <= 1'b0;
        else       lb_q <= lb_en;
    end
    assign lb_active = lb_q;
`else
    assign lb_active = 1'b0;
`endif

    assign lb_move       = lb_active && !out_empty && !in_full;

    assign host_in_ready = !in_full && !lb_active;
    assign in_push       = (host_in_valid && host_in_ready) || lb_move;
    assign in_wdata      = lb_move ? out_rdata : host_in_data;
    assign in_pop        = cpu_in_rd && !in_empty;

    // A full output FIFO drops the OUT word even if the host pops in the same cycle.
    assign host_out_valid = !out_empty && !lb_active;
    assign host_out_data  = out_rdata;
    assign out_push       = cpu_out_wr && !out_full;
    assign out_pop        = (host_out_valid && host_out_ready) || lb_move;

    assign unused_counts  = ^{in_count, out_count};

    io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (in_wdata),
        .rdata (cpu_in_data),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .pop   (out_pop),
        .wdata (cpu_out_data),
        .rdata (out_rdata),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (cpu_out_wr && out_full) ovf_err <= 1'b1;
            if (cpu_in_rd && in_empty)  udf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            irq   <= (state_nx == ASSERT);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (in_push && in_empty) begin
                    state_nx = ASSERT;
                    cnt_nx   = CNT_W'(IRQ_LEN - 1);
                end
            end
            ASSERT: begin
                if (cnt == '0) state_nx = WAIT;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
            WAIT: begin
                if (in_empty) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
